rand_draw: RTL and testbench
============================

// Module: rand_draw
// PURPOSE
//  - Consumes the 8-bit pseudo-random stream from the upstream LFSR (one new word per clk) and turns it
//    into a uniform draw in 0..RANGE-1 (dice/lottery value) on a start request.
//  - Shows a "rolling" animation on value for ROLL_CYCLES cycles, then draws by rejection sampling.
//  - The value/valid pair feeds the display/decoder stage downstream.
// PARAMETERS
//  - RANGE        6    number of outcomes; legal 2..256; W = clog2(RANGE), MASK = 2^W-1
//  - ROLL_CYCLES  16   animation length in cycles; legal >=1
//  - MAX_TRIES    8    rejection attempts before deterministic fallback; legal >=1
// PORTS
//  - clk     in   1  single system clock; all state on rising edge
//  - reset   in   1  synchronous, active-high reset
//  - start   in   1  draw request (debounced level/pulse); sampled only in IDLE and DONE
//  - rnd     in   8  LFSR word; advances every cycle
//  - value   out  8  current draw / animation value, zero-extended from W bits
//  - valid   out  1  high while value holds an accepted draw
//  - busy    out  1  high in ROLL or DRAW
// BEHAVIOUR
//  - Reset: state=IDLE, value=0, valid=0, busy=0, roll_cnt=0, tries=0, last=0. Reset in any state
//    (mid-ROLL/DRAW included) aborts at once; reset wins over start.
//  - cand = rnd & MASK; fold(x) = (x>=RANGE) ? x-RANGE : x, always < RANGE since MASK < 2*RANGE.
//  - IDLE: start=1 -> ROLL, roll_cnt<=ROLL_CYCLES-1, valid<=0.
//  - ROLL: value<=fold(cand) every cycle; roll_cnt!=0 -> decrement;
//    roll_cnt==0 -> DRAW, tries<=0. Start is ignored.
//  - DRAW: accept if cand<RANGE (plus history rule below):
//    value<=cand, last<=cand, valid<=1 -> DONE. Otherwise tries++.
//    On the attempt where tries==MAX_TRIES-1, force-accept fold(cand) -> DONE. Start is ignored.
//  - DONE: value/valid held; start=1 -> ROLL exactly as from IDLE (valid<=0 on that edge).
//  - Latency: with start sampled at edge E0, busy=1 after E0.
//    The first DRAW sample is at edge E0+ROLL_CYCLES+1; best-case valid=1 after that edge.
//    Worst case is MAX_TRIES-1 cycles later.
//  - busy = (state==ROLL)|(state==DRAW); valid and busy are never both 1.
//  - rnd==0 is legal (cand 0 is accepted); block never stalls beyond MAX_TRIES.
// CONFIGURATION
//  - RAND_DRAW_NO_REPEAT_EN defined: no-repeat mode. A DRAW candidate equal to last is also rejected.
//    If the forced fallback equals last, value<=(last+1==RANGE)?0:last+1.
//    last is updated on every accept; after reset last=0, so the first draw cannot be 0.
//  - Undefined: repeats allowed; last register and compare are not built.
// STRUCTURE
//  - Shared include rand_draw_defs.vh: state encodings (IDLE=2'd0, ROLL=2'd1, DRAW=2'd2, DONE=2'd3).
//  - One sub-module, range_fold: combinational (rnd, RANGE) -> cand, in_range, folded.
//  - Top holds the FSM, roll_cnt, tries, last and output registers.
// TESTING (RANGE=6, ROLL_CYCLES=4, MAX_TRIES=8; bench drives rnd directly)
//  - Reset: assert reset 2 cycles -> value=0, valid=0, busy=0; start with reset high -> still IDLE.
//  - Basic: start pulse at E0, rnd=8'h0B at E5 -> busy 1 after E0..E5, value=3, valid=1 after E5.
//  - Rejection: DRAW rnd sequence 8'h07, 8'h06, 8'h02 -> value=2, valid=1 after the 3rd DRAW edge.
//  - Fallback: rnd held 8'h0F through DRAW -> 8 attempts, then value=1 (7-6), valid=1.
//  - Abort/ignore: start during ROLL/DRAW has no effect.
//    Reset mid-ROLL -> IDLE, value=0; new start -> full ROLL again.
//  - No-repeat: last=3, DRAW rnd 8'h03 then 8'h04:
//    with RAND_DRAW_NO_REPEAT_EN -> value=4; without -> value=3.

Source files
------------

// File: rtl/rand_draw_pkg.sv
// Shared types for the rand_draw slice: FSM state encodings and draw-width helper.
// No logic, no latency; no backpressure (definitions only).
// Optional no-repeat mode is selected in rand_draw.sv by RAND_DRAW_NO_REPEAT_EN.
package rand_draw_pkg;

  localparam int RND_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ROLL = 2'd1,
    DRAW = 2'd2,
    DONE = 2'd3
  } state_t;

  // Candidate width: smallest W with 2^W >= range, never below one bit.
  function automatic int draw_width(input int range);
    return (range <= 2) ? 1 : $clog2(range);
  endfunction

endpackage

// File: rtl/rand_draw_range_fold.sv
// range_fold: masks an LFSR word to W bits and folds it into 0..RANGE-1.
// Purely combinational, zero latency; no backpressure.
// Folding needs only one subtract because the mask is always below 2*RANGE.
module range_fold
  import rand_draw_pkg::*;
#(
  parameter int RANGE = 6,
  parameter int W     = draw_width(RANGE)
) (
  input  logic [RND_W-1:0] rnd,
  output logic [W-1:0]     cand,
  output logic             in_range,
  output logic [W-1:0]     folded
);

  localparam logic [8:0] RANGE9 = 9'(RANGE);

  logic [8:0] cand9;

  assign cand     = rnd[W-1:0];
  assign cand9    = 9'(cand);
  assign in_range = cand9 < RANGE9;
  assign folded   = in_range ? cand : W'(cand9 - RANGE9);

endmodule

// File: rtl/rand_draw.sv
// rand_draw: uniform 0..RANGE-1 draw from an LFSR stream, with a rolling animation first.
// Latency: ROLL_CYCLES+1 edges after start to first draw sample, up to MAX_TRIES-1 more on rejects.
// No backpressure: start is ignored while busy; RAND_DRAW_NO_REPEAT_EN forbids repeating the last draw.
module rand_draw
  import rand_draw_pkg::*;
#(
  parameter int RANGE       = 6,
  parameter int ROLL_CYCLES = 16,
  parameter int MAX_TRIES   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [RND_W-1:0] rnd,
  output logic [RND_W-1:0] value,
  output logic             valid,
  output logic             busy
);

  localparam int W  = draw_width(RANGE);
  localparam int RW = $clog2(ROLL_CYCLES + 1);
  localparam int TW = $clog2(MAX_TRIES + 1);

  state_t         state;
  logic [W-1:0]   val_q;
  logic [RW-1:0]  roll_cnt;
  logic [TW-1:0]  tries;
  logic [W-1:0]   cand;
  logic           in_range;
  logic [W-1:0]   folded;
  logic           accept;
  logic [W-1:0]   fallback;

  range_fold #(.RANGE(RANGE), .W(W)) u_fold (
    .rnd      (rnd),
    .cand     (cand),
    .in_range (in_range),
    .folded   (folded)
  );

`ifdef RAND_DRAW_NO_REPEAT_EN
  logic [W-1:0] last;

  // A forced fallback that collides with the previous draw steps to the next value, wrapping at RANGE.
  always_comb begin
    accept   = in_range && (cand != last);
    fallback = folded;
    if (folded == last)
      fallback = (9'(last) + 9'd1 == 9'(RANGE)) ? '0 : W'(9'(last) + 9'd1);
  end
`else
  assign accept   = in_range;
  assign fallback = folded;
`endif

  assign value = RND_W'(val_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      val_q    <= '0;
      valid    <= 1'b0;
      busy     <= 1'b0;
      roll_cnt <= '0;
      tries    <= '0;
`ifdef RAND_DRAW_NO_REPEAT_EN
      last     <= '0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state    <= ROLL;
            roll_cnt <= RW'(ROLL_CYCLES - 1);
            valid    <= 1'b0;
            busy     <= 1'b1;
          end
        end
        ROLL: begin
          val_q <= folded;
          if (roll_cnt != '0) begin
            roll_cnt <= roll_cnt - 1'b1;
          end else begin
            state <= DRAW;
            tries <= '0;
          end
        end
        DRAW: begin
          if (accept) begin
            val_q <= cand;
`ifdef RAND_DRAW_NO_REPEAT_EN
            last  <= cand;
`endif
            valid <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end else if (tries == TW'(MAX_TRIES - 1)) begin
            val_q <= fallback;
`ifdef RAND_DRAW_NO_REPEAT_EN
            last  <= fallback;
`endif
            valid <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end else begin
            tries <= tries + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rand_draw.sv
// Bench for rand_draw (RANGE=6, ROLL_CYCLES=4, MAX_TRIES=8) with rnd driven directly.
// Accepted draws are predicted into a queue and checked by a monitor when valid rises.
module tb_rand_draw;

  localparam int RANGE = 6;
  localparam int ROLL  = 4;
  localparam int MAXT  = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [7:0] rnd = 8'h00;
  logic [7:0] value;
  logic       valid;
  logic       busy;

  typedef struct {
    logic [7:0] val;
    int         edge_n;
  } exp_t;

  exp_t       sb[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  int         cyc     = 0;
  logic       valid_d = 1'b0;
  logic [7:0] seq[0:7];
  int         seq_len = 1;
  bit         poke_start = 1'b0;

  rand_draw #(.RANGE(RANGE), .ROLL_CYCLES(ROLL), .MAX_TRIES(MAXT)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .rnd   (rnd),
    .value (value),
    .valid (valid),
    .busy  (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] fold_ref(input logic [7:0] x);
    logic [7:0] m;
    m = x & 8'h07;
    return (m >= 8'(RANGE)) ? m - 8'(RANGE) : m;
  endfunction

  // Scoreboard monitor: every rising valid must match the oldest prediction, value and edge.
  always @(negedge clk) begin
    exp_t e;
    if (valid === 1'b1 && valid_d !== 1'b1) begin
      if (sb.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_valid value=%0d at edge %0d", value, cyc);
      end else begin
        e = sb.pop_front();
        n_tests++;
        if (value !== e.val) begin
          n_fail++;
          $display("FAIL draw_value got=%0d expected=%0d", value, e.val);
        end
        n_tests++;
        if (cyc !== e.edge_n) begin
          n_fail++;
          $display("FAIL draw_latency valid at edge %0d expected edge %0d", cyc, e.edge_n);
        end
      end
    end
    if (valid === 1'b1 && busy === 1'b1) begin
      n_fail++;
      $display("FAIL valid_busy_overlap at edge %0d", cyc);
    end
    valid_d = valid;
  end

  // Drives one draw: random rnd during ROLL, seq[] during DRAW (last entry repeats).
  task automatic drive_draw(input logic [7:0] ev, input int eidx);
    int e0;
    logic [7:0] prev;
    exp_t e;
    @(negedge clk);
    start = 1'b1;
    rnd   = 8'($urandom);
    prev  = rnd;
    e0    = cyc + 1;
    e.val = ev;
    e.edge_n = e0 + ROLL + 1 + eidx;
    sb.push_back(e);
    for (int k = 1; k < ROLL + 1 + MAXT + 4; k++) begin
      @(negedge clk);
      if (valid === 1'b1) break;
      start = poke_start ? (k % 2 == 0) : 1'b0;
      n_tests++;
      if (busy !== 1'b1) begin
        n_fail++;
        $display("FAIL busy_during_draw got=%b expected=1 at edge %0d", busy, cyc);
      end
      if (k >= 2 && k <= ROLL + 1) begin
        n_tests++;
        if (value !== fold_ref(prev)) begin
          n_fail++;
          $display("FAIL roll_animation got=%0d expected=%0d", value, fold_ref(prev));
        end
      end
      if (k <= ROLL) rnd = 8'($urandom);
      else rnd = seq[(k - ROLL - 1 < seq_len) ? k - ROLL - 1 : seq_len - 1];
      prev = rnd;
    end
    start = 1'b0;
    @(negedge clk);
    if (sb.size() != 0) begin
      n_tests++; n_fail++;
      $display("FAIL draw_timeout valid never rose, expected value=%0d", ev);
      sb.delete();
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    start = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++;
    if (value !== 8'd0) begin n_fail++; $display("FAIL reset_value got=%0d expected=0", value); end
    n_tests++;
    if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b expected=0", valid); end
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b expected=0", busy); end
    reset = 1'b0;
    start = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if (busy !== 1'b0 || valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_over_start busy=%b valid=%b expected idle", busy, valid);
    end
  endtask

  task automatic test_basic();
    seq[0] = 8'h0B; seq_len = 1;
    drive_draw(8'd3, 0);
    repeat (2) @(negedge clk);
    n_tests++;
    if (valid !== 1'b1 || busy !== 1'b0 || value !== 8'd3) begin
      n_fail++;
      $display("FAIL done_hold valid=%b busy=%b value=%0d expected 1/0/3", valid, busy, value);
    end
  endtask

  task automatic test_rejection();
    seq[0] = 8'h07; seq[1] = 8'h06; seq[2] = 8'h02; seq_len = 3;
    drive_draw(8'd2, 2);
  endtask

  task automatic test_fallback();
    seq[0] = 8'h0F; seq_len = 1;
    drive_draw(8'd1, MAXT - 1);
  endtask

  task automatic test_ignore_start();
    poke_start = 1'b1;
    seq[0] = 8'h07; seq[1] = 8'h07; seq[2] = 8'h05; seq_len = 3;
    drive_draw(8'd5, 2);
    poke_start = 1'b0;
  endtask

  task automatic test_abort();
    @(negedge clk);
    start = 1'b1;
    rnd   = 8'h0B;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if (busy !== 1'b1 || value !== 8'd3 || valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_roll busy=%b value=%0d valid=%b expected 1/3/0", busy, value, valid);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_tests++;
    if (busy !== 1'b0 || value !== 8'd0 || valid !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_reset busy=%b value=%0d valid=%b expected 0/0/0", busy, value, valid);
    end
    seq[0] = 8'h0B; seq_len = 1;
    drive_draw(8'd3, 0);
  endtask

  task automatic test_no_repeat();
    seq[0] = 8'h03; seq[1] = 8'h04; seq_len = 2;
`ifdef RAND_DRAW_NO_REPEAT_EN
    drive_draw(8'd4, 1);
`else
    drive_draw(8'd3, 0);
`endif
  endtask

  task automatic test_zero_word();
    seq[0] = 8'h00; seq_len = 1;
    drive_draw(8'd0, 0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rejection();
    test_fallback();
    test_ignore_start();
    test_abort();
    test_no_repeat();
    test_zero_word();
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
